control_unit_risc: RTL and testbench

- Multi-cycle Moore FSM that sequences the RISC-SPM datapath: fetch, decode, execute.
- Drives register, PC, IR, address-register, Reg_Y and Reg_Z load strobes, both bus mux selects, memory write, and the ALU opcode select.
- Sits directly upstream of the ALU: it chooses the ALU operation and the operand paths.
- Consumes the current instruction word from IR and the registered zero flag from Reg_Z.

---
 rtl/control_unit_risc_pkg.sv | 50 +++++
 rtl/control_unit_risc.sv | 168 ++++++++++++++++
 tb/tb_control_unit_risc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_risc_pkg.sv
// Shared encodings for the RISC-SPM controller: opcodes (common with the ALU),
// FSM states, bus mux select codes and instruction field positions.
package control_unit_risc_pkg;

    localparam int WORD_SIZE = 8;
    localparam int OP_SIZE   = 4;
    localparam int SEL1_SIZE = 3;
    localparam int SEL2_SIZE = 2;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 4;
    localparam int SRC_MSB  = 3;
    localparam int SRC_LSB  = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_RD  = 4'h5;
    localparam logic [3:0] OP_WR  = 4'h6;
    localparam logic [3:0] OP_BR  = 4'h7;
    localparam logic [3:0] OP_BRZ = 4'h8;
    localparam logic [3:0] OP_EQZ = 4'h9;
    localparam logic [3:0] OP_LDR = 4'hA;

    localparam logic [2:0] SEL1_R0 = 3'd0;
    localparam logic [2:0] SEL1_R1 = 3'd1;
    localparam logic [2:0] SEL1_R2 = 3'd2;
    localparam logic [2:0] SEL1_R3 = 3'd3;
    localparam logic [2:0] SEL1_PC = 3'd4;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        S_idle, S_fet1, S_fet2, S_dec, S_ex1,
        S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2,
        S_brz, S_ldr1, S_halt
    } state_t;

    // One-hot register file load strobe for a destination field.
    function automatic logic [3:0] dest_load(input logic [1:0] dest);
        return 4'b0001 << dest;
    endfunction

endpackage

// File: rtl/control_unit_risc.sv
// Multi-cycle Moore controller for the RISC-SPM datapath (fetch, decode, execute).
// Outputs decode combinationally from the state register and the IR fields.
// Synchronous active-low reset returns to S_idle and abandons any instruction.
module control_unit_risc
    import control_unit_risc_pkg::*;
#(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int sel1_size = 3,
    parameter int sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 load_r0,
    output logic                 load_r1,
    output logic                 load_r2,
    output logic                 load_r3,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic [sel1_size-1:0] sel_bus_1_mux,
    output logic [sel2_size-1:0] sel_bus_2_mux,
    output logic [op_size-1:0]   alu_sel,
    output logic                 write,
    output logic                 halted
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  opcode;
    logic [1:0]  src;
    logic [1:0]  dest;
    logic [3:0]  load_r;
    logic [2:0]  sel1;
    logic [1:0]  sel2;

    assign opcode = instruction[OPC_MSB:OPC_LSB];
    assign src    = instruction[SRC_MSB:SRC_LSB];
    assign dest   = instruction[DEST_MSB:DEST_LSB];

    always_ff @(posedge clk) begin
        if (!rst) state <= S_idle;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write      = 1'b0;
        halted     = 1'b0;
        sel1       = SEL1_R0;
        // Idle-time default keeps the ALU opcode at NOP outside ALU cycles.
        sel2       = SEL2_BUS1;
        case (state)
            S_idle: begin
                sel2       = SEL2_ALU;
                next_state = S_fet1;
            end
            S_fet1: begin
                sel1       = SEL1_PC;
                load_add_r = 1'b1;
                next_state = S_fet2;
            end
            S_fet2: begin
                sel2       = SEL2_MEM;
                load_ir    = 1'b1;
                inc_pc     = 1'b1;
                next_state = S_dec;
            end
            S_dec: begin
                case (opcode)
                    OP_NOP: next_state = S_fet1;
                    OP_ADD, OP_SUB, OP_AND, OP_EQZ: begin
                        sel1       = {1'b0, src};
                        load_reg_y = 1'b1;
                        next_state = S_ex1;
                    end
                    OP_NOT: begin
                        sel1       = {1'b0, src};
                        sel2       = SEL2_ALU;
                        load_reg_z = 1'b1;
                        load_r     = dest_load(dest);
                        next_state = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR, OP_BRZ: begin
                        // Operand address byte follows the opcode, so it is fetched via PC.
                        sel1       = SEL1_PC;
                        load_add_r = 1'b1;
                        inc_pc     = (opcode == OP_RD) || (opcode == OP_WR);
                        next_state = (opcode == OP_RD) ? S_rd1 :
                                     (opcode == OP_WR) ? S_wr1 :
                                     (opcode == OP_BR) ? S_br1 : S_brz;
                    end
                    OP_LDR: begin
                        sel1       = {1'b0, src};
                        load_add_r = 1'b1;
                        next_state = S_ldr1;
                    end
                    default: next_state = S_halt;
                endcase
            end
            S_ex1: begin
                sel1       = {1'b0, dest};
                sel2       = SEL2_ALU;
                load_reg_z = 1'b1;
                if (opcode != OP_EQZ) load_r = dest_load(dest);
                next_state = S_fet1;
            end
            S_rd1, S_wr1, S_br1: begin
                sel2       = SEL2_MEM;
                load_add_r = 1'b1;
                next_state = (state == S_rd1) ? S_rd2 :
                             (state == S_wr1) ? S_wr2 : S_br2;
            end
            S_rd2, S_ldr1: begin
                sel2       = SEL2_MEM;
                load_r     = dest_load(dest);
                next_state = S_fet1;
            end
            S_wr2: begin
                sel1       = {1'b0, src};
                write      = 1'b1;
                next_state = S_fet1;
            end
            S_br2: begin
                sel2       = SEL2_MEM;
                load_pc    = 1'b1;
                next_state = S_fet1;
            end
            S_brz: begin
                if (zero) begin
                    sel2       = SEL2_MEM;
                    load_add_r = 1'b1;
                    next_state = S_br2;
                end else begin
                    // Not taken: step PC over the branch address byte.
                    inc_pc     = 1'b1;
                    next_state = S_fet1;
                end
            end
            S_halt: begin
                halted     = 1'b1;
                next_state = S_halt;
            end
            default: next_state = S_idle;
        endcase
    end

    assign load_r0       = load_r[0];
    assign load_r1       = load_r[1];
    assign load_r2       = load_r[2];
    assign load_r3       = load_r[3];
    assign sel_bus_1_mux = sel1;
    assign sel_bus_2_mux = sel2;
    assign alu_sel       = (sel2 == SEL2_ALU && state != S_idle) ? opcode : OP_NOP;

endmodule

// File: tb/tb_control_unit_risc.sv
// Scoreboard bench: a per-instruction micro-step model queues expected outputs,
// a negedge monitor pops and compares them against the controller.
module tb_control_unit_risc;

    typedef struct {
        string       name;
        logic [11:0] strb;
        logic [2:0]  sel1;
        bit          c1;
        logic [1:0]  sel2;
        bit          c2;
        logic [3:0]  alu;
        bit          ca;
    } exp_t;

    // Strobe bit masks: {halted, write, reg_z, reg_y, add_r, ir, inc_pc, pc, r3..r0}
    localparam logic [11:0] M_PC   = 12'h010;
    localparam logic [11:0] M_INC  = 12'h020;
    localparam logic [11:0] M_IR   = 12'h040;
    localparam logic [11:0] M_ADD  = 12'h080;
    localparam logic [11:0] M_Y    = 12'h100;
    localparam logic [11:0] M_Z    = 12'h200;
    localparam logic [11:0] M_WR   = 12'h400;
    localparam logic [11:0] M_HALT = 12'h800;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;
    logic       load_r0, load_r1, load_r2, load_r3;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
    logic [2:0] sel_bus_1_mux;
    logic [1:0] sel_bus_2_mux;
    logic [3:0] alu_sel;
    logic       write, halted;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t plan[$];

    control_unit_risc dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
        .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir), .load_add_r(load_add_r),
        .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
        .sel_bus_1_mux(sel_bus_1_mux), .sel_bus_2_mux(sel_bus_2_mux),
        .alu_sel(alu_sel), .write(write), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [11:0] s,
                                input logic [2:0] s1, input bit c1,
                                input logic [1:0] s2, input bit c2,
                                input logic [3:0] a, input bit ca);
        exp_t e;
        e.name = n; e.strb = s; e.sel1 = s1; e.c1 = c1;
        e.sel2 = s2; e.c2 = c2; e.alu = a; e.ca = ca;
        return e;
    endfunction

    function automatic logic [11:0] ld(input logic [1:0] d);
        return 12'h001 << d;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting at its first fetch cycle.
    function automatic void plan_instr(input logic [7:0] ins, input logic z);
        logic [3:0] op;
        logic [1:0] s;
        logic [1:0] d;
        op = ins[7:4];
        s  = ins[3:2];
        d  = ins[1:0];
        plan.delete();
        plan.push_back(mk("fetch1", M_ADD, 3'd4, 1, 2'd1, 1, 4'd0, 1));
        plan.push_back(mk("fetch2", M_IR | M_INC, 3'd0, 0, 2'd2, 1, 4'd0, 1));
        case (op)
            4'h0: plan.push_back(mk("nop.dec", 12'h000, 3'd0, 0, 2'd0, 0, 4'd0, 0));
            4'h1, 4'h2, 4'h3, 4'h9: begin
                plan.push_back(mk("alu.dec", M_Y, {1'b0, s}, 1, 2'd1, 1, 4'd0, 1));
                plan.push_back(mk("alu.exec", M_Z | ((op == 4'h9) ? 12'h000 : ld(d)),
                                  {1'b0, d}, 1, 2'd0, 1, op, 1));
            end
            4'h4: plan.push_back(mk("not.dec", M_Z | ld(d), {1'b0, s}, 1, 2'd0, 1, op, 1));
            4'h5, 4'h6, 4'h7, 4'h8: begin
                plan.push_back(mk("mem.dec", M_ADD | ((op == 4'h5 || op == 4'h6) ? M_INC : 12'h000),
                                  3'd4, 1, 2'd1, 1, 4'd0, 1));
                if (op == 4'h8 && !z) begin
                    plan.push_back(mk("brz.skip", M_INC, 3'd0, 0, 2'd0, 0, 4'd0, 0));
                end else begin
                    plan.push_back(mk("mem.addr", M_ADD, 3'd0, 0, 2'd2, 1, 4'd0, 1));
                    if (op == 4'h5)
                        plan.push_back(mk("rd.load", ld(d), 3'd0, 0, 2'd2, 1, 4'd0, 1));
                    else if (op == 4'h6)
                        plan.push_back(mk("wr.store", M_WR, {1'b0, s}, 1, 2'd0, 0, 4'd0, 0));
                    else
                        plan.push_back(mk("br.jump", M_PC, 3'd0, 0, 2'd2, 1, 4'd0, 1));
                end
            end
            4'hA: begin
                plan.push_back(mk("ldr.dec", M_ADD, {1'b0, s}, 1, 2'd1, 1, 4'd0, 1));
                plan.push_back(mk("ldr.load", ld(d), 3'd0, 0, 2'd2, 1, 4'd0, 1));
            end
            default: begin
                plan.push_back(mk("illegal.dec", 12'h000, 3'd0, 0, 2'd0, 0, 4'd0, 0));
                for (int i = 0; i < 12; i++)
                    plan.push_back(mk("halt", M_HALT, 3'd0, 0, 2'd0, 0, 4'd0, 0));
            end
        endcase
    endfunction

    task automatic run_instr(input logic [7:0] ins, input logic z, input int limit);
        plan_instr(ins, z);
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            @(posedge clk);
            #1;
            instruction = ins;
            zero = z;
            exp_q.push_back(plan[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(mk("reset_idle", 12'h000, 3'd0, 1, 2'd0, 1, 4'd0, 1));
        end
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [11:0] act;
            e = exp_q.pop_front();
            act = {halted, write, load_reg_z, load_reg_y, load_add_r, load_ir,
                   inc_pc, load_pc, load_r3, load_r2, load_r1, load_r0};
            checks++;
            if (act !== e.strb) begin
                errors++;
                $display("FAIL %s.strobes got %03h want %03h", e.name, act, e.strb);
            end
            if (e.c1) begin
                checks++;
                if (sel_bus_1_mux !== e.sel1) begin
                    errors++;
                    $display("FAIL %s.sel_bus_1 got %0d want %0d", e.name, sel_bus_1_mux, e.sel1);
                end
            end
            if (e.c2) begin
                checks++;
                if (sel_bus_2_mux !== e.sel2) begin
                    errors++;
                    $display("FAIL %s.sel_bus_2 got %0d want %0d", e.name, sel_bus_2_mux, e.sel2);
                end
            end
            if (e.ca) begin
                checks++;
                if (alu_sel !== e.alu) begin
                    errors++;
                    $display("FAIL %s.alu_sel got %0d want %0d", e.name, alu_sel, e.alu);
                end
            end
        end
    end

    initial begin
        logic [7:0] directed [0:12];
        logic       dir_z    [0:12];
        logic [7:0] ins;
        directed = '{8'h16, 8'h9E, 8'h4B, 8'h80, 8'h80, 8'h53, 8'h68,
                     8'h00, 8'hA6, 8'h70, 8'h25, 8'h35, 8'h15};
        dir_z    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 13; i++) run_instr(directed[i], dir_z[i], 100);
        for (int i = 0; i < 150; i++) begin
            ins = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 15))};
            run_instr(ins, 1'($urandom_range(0, 1)), 100);
        end
        // Reset while waiting in the read address cycle: the pending load_r3 must never appear.
        run_instr(8'h53, 1'b0, 4);
        do_reset();
        run_instr(8'h00, 1'b0, 100);
        run_instr(8'hF0, 1'b0, 100);
        do_reset();
        run_instr(8'h4B, 1'b1, 100);
        for (int i = 0; i < 2; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
